// File: rtl/kmeans_mulit_arb.sv
// Grants one requester per cycle onto a shared LAT-stage 16x16 multiplier; the response appears LAT cycles after the grant, with no back-pressure.
// KMEANS_MULIT_ARB_RR_EN selects round-robin arbitration; without it the lowest requesting index always wins.
module kmeans_mulit_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 4
) (
  input  logic               mulit_clk,
  input  logic               mulit_rst,
  input  logic               arb_en,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic [15:0]        mul_a,
  output logic [15:0]        mul_b,
  input  logic [31:0]        mul_out,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_data,
  output logic               busy
);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  tag_t            tag_q [LAT];
  logic [NREQ-1:0] req_act;
  logic [NREQ-1:0] cand;
  logic            grant_vld;
  logic [IDW-1:0]  grant_id;

  // Reset also masks requests so nothing is granted while the pipe is held clear.
  assign req_act = (arb_en && mulit_rst) ? req_valid : '0;

`ifdef KMEANS_MULIT_ARB_RR_EN
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] hi_req;

  // Requests above the last grant go first; if none, wrap to the lowest index.
  always_comb begin
    hi_req = '0;
    for (int i = 0; i < NREQ; i++) begin
      hi_req[i] = req_act[i] && (IDW'(i) > rr_ptr);
    end
    cand = (|hi_req) ? hi_req : req_act;
  end

  always_ff @(posedge mulit_clk or negedge mulit_rst) begin
    if (!mulit_rst) begin
      rr_ptr <= IDW'(NREQ - 1);
    end else if (grant_vld) begin
      rr_ptr <= grant_id;
    end
  end
`else
  assign cand = req_act;
`endif

  always_comb begin
    grant_vld = |cand;
    grant_id  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand[i]) grant_id = IDW'(i);
    end
  end

  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_vld && (grant_id == IDW'(i))) begin
        req_ready[i] = 1'b1;
        mul_a        = req_a[16*i +: 16];
        mul_b        = req_b[16*i +: 16];
      end
    end
  end

  // Tag pipe mirrors the multiplier depth so the id lines up with mul_out.
  always_ff @(posedge mulit_clk or negedge mulit_rst) begin
    if (!mulit_rst) begin
      for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= tag_t'{vld: grant_vld, id: grant_id};
      for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < LAT; s++) busy = busy | tag_q[s].vld;
  end

  assign rsp_valid = tag_q[LAT-1].vld;
  assign rsp_id    = tag_q[LAT-1].id;
  assign rsp_data  = mul_out;

endmodule
